// File: rtl/float_pkg.sv
// Shared encodings and helpers for the floating-point multiplier datapath.
package float_pkg;

  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_OVF  = 2'b01;
  localparam logic [1:0] FLAG_UDF  = 2'b10;
  localparam logic [1:0] FLAG_NAN  = 2'b11;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fclass_e;

  function automatic int float_bias(int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Quiet NaN with positive sign, all-ones exponent and only the top fraction bit set.
  function automatic logic [63:0] canon_nan(int exp_w, int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/float_round_ne.sv
// Normalises the raw mantissa product to one leading integer bit and rounds to
// nearest, ties to even, adjusting the exponent for both the normalise shift
// and a rounding carry-out.
module float_round_ne
  import float_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [2*MAN_W+1:0]        prod,
  input  logic signed [EXP_W+1:0]   exp_in,
  output logic [MAN_W-1:0]          frac,
  output logic signed [EXP_W+1:0]   exp_out
);

  logic [2*MAN_W+1:0] norm;
  logic [MAN_W:0]     mant;
  logic [MAN_W+1:0]   mant_rnd;
  logic               guard;
  logic               sticky;
  logic               round_up;

  // Product of two [1,2) mantissas lies in [1,4); left-align it, then round.
  always_comb begin
    norm     = prod[2*MAN_W+1] ? prod : (prod << 1);
    mant     = norm[2*MAN_W+1 -: MAN_W+1];
    guard    = norm[MAN_W];
    sticky   = |norm[MAN_W-1:0];
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
    frac     = mant_rnd[MAN_W+1] ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
    exp_out  = exp_in
             + $signed({{(EXP_W+1){1'b0}}, prod[2*MAN_W+1]})
             + $signed({{(EXP_W+1){1'b0}}, mant_rnd[MAN_W+1]});
  end

endmodule

// File: rtl/float_mul_pipe.sv
// Fully pipelined floating-point multiplier with valid/ready flow control.
// Ranks: input capture, unpack, multiply, normalise/round, pack/flags.
// A single advance enable freezes every rank while the output is stalled.
module float_mul_pipe
  import float_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   x,
  input  logic [EXP_W+MAN_W:0]   y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   z,
  output logic [1:0]             overflow
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic signed [EXP_W+1:0] BIAS    = (EXP_W+2)'(float_bias(EXP_W));
  localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic [63:0]             QNAN64  = canon_nan(EXP_W, MAN_W);

  function automatic fclass_e classify(logic [EXP_W-1:0] e, logic [MAN_W-1:0] f);
    if (e == '0) return ZERO;
    if (e == '1) return (f == '0) ? INF : NAN;
    return NORM;
  endfunction

  logic advance;

  logic         v0;
  logic [W-1:0] x0, y0;

  fclass_e                 cls_x, cls_y;
  logic                    s1_nan, s1_inf, s1_zero;
  logic signed [EXP_W+1:0] s1_exp;

  logic                    v1, r1_sign, r1_nan, r1_inf, r1_zero;
  logic signed [EXP_W+1:0] r1_exp;
  logic [MAN_W:0]          r1_mx, r1_my;

  logic                    v2, r2_sign, r2_nan, r2_inf, r2_zero;
  logic signed [EXP_W+1:0] r2_exp;
  logic [2*MAN_W+1:0]      r2_prod;

  logic [MAN_W-1:0]        s3_frac;
  logic signed [EXP_W+1:0] s3_exp;

  logic                    v3, r3_sign, r3_nan, r3_inf, r3_zero;
  logic signed [EXP_W+1:0] r3_exp;
  logic [MAN_W-1:0]        r3_frac;

  logic [W-1:0]            z_d;
  logic [1:0]              flag_d;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Capture the operand pair; an unaccepted cycle becomes a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0;
      x0 <= '0;
      y0 <= '0;
    end else if (advance) begin
      v0 <= in_valid;
      x0 <= x;
      y0 <= y;
    end
  end

  // Unpack: classify operands (subnormals treated as zero) and form the unbiased-sum exponent.
  always_comb begin
    cls_x   = classify(x0[W-2 -: EXP_W], x0[MAN_W-1:0]);
    cls_y   = classify(y0[W-2 -: EXP_W], y0[MAN_W-1:0]);
    s1_nan  = (cls_x == NAN) || (cls_y == NAN)
           || (cls_x == INF && cls_y == ZERO) || (cls_x == ZERO && cls_y == INF);
    s1_inf  = (cls_x == INF) || (cls_y == INF);
    s1_zero = (cls_x == ZERO) || (cls_y == ZERO);
    s1_exp  = $signed({2'b00, x0[W-2 -: EXP_W]}) + $signed({2'b00, y0[W-2 -: EXP_W]}) - BIAS;
  end

  // Unpack rank registers, hidden bit attached to each mantissa.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; r1_sign <= 1'b0; r1_nan <= 1'b0; r1_inf <= 1'b0; r1_zero <= 1'b0;
      r1_exp <= '0; r1_mx <= '0; r1_my <= '0;
    end else if (advance) begin
      v1      <= v0;
      r1_sign <= x0[W-1] ^ y0[W-1];
      r1_nan  <= s1_nan;
      r1_inf  <= s1_inf;
      r1_zero <= s1_zero;
      r1_exp  <= s1_exp;
      r1_mx   <= {1'b1, x0[MAN_W-1:0]};
      r1_my   <= {1'b1, y0[MAN_W-1:0]};
    end
  end

  // Multiply rank: full-width unsigned mantissa product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0; r2_sign <= 1'b0; r2_nan <= 1'b0; r2_inf <= 1'b0; r2_zero <= 1'b0;
      r2_exp <= '0; r2_prod <= '0;
    end else if (advance) begin
      v2      <= v1;
      r2_sign <= r1_sign;
      r2_nan  <= r1_nan;
      r2_inf  <= r1_inf;
      r2_zero <= r1_zero;
      r2_exp  <= r1_exp;
      r2_prod <= r1_mx * r1_my;
    end
  end

  float_round_ne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .prod    (r2_prod),
    .exp_in  (r2_exp),
    .frac    (s3_frac),
    .exp_out (s3_exp)
  );

  // Normalise/round rank registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3 <= 1'b0; r3_sign <= 1'b0; r3_nan <= 1'b0; r3_inf <= 1'b0; r3_zero <= 1'b0;
      r3_exp <= '0; r3_frac <= '0;
    end else if (advance) begin
      v3      <= v2;
      r3_sign <= r2_sign;
      r3_nan  <= r2_nan;
      r3_inf  <= r2_inf;
      r3_zero <= r2_zero;
      r3_exp  <= s3_exp;
      r3_frac <= s3_frac;
    end
  end

  // Pack with exception priority: NaN, inf operand, zero operand, overflow, underflow, normal.
  always_comb begin
    z_d    = {r3_sign, r3_exp[EXP_W-1:0], r3_frac};
    flag_d = FLAG_NONE;
    if (r3_nan) begin
      z_d    = QNAN64[W-1:0];
      flag_d = FLAG_NAN;
    end else if (r3_inf) begin
      z_d = {r3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (r3_zero) begin
      z_d = {r3_sign, {(W-1){1'b0}}};
    end else if (r3_exp >= EXP_MAX) begin
      z_d    = {r3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flag_d = FLAG_OVF;
    end else if (r3_exp[EXP_W+1] || r3_exp == '0) begin
      z_d    = {r3_sign, {(W-1){1'b0}}};
      flag_d = FLAG_UDF;
    end
  end

  // Output rank: result and its own flags, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      z         <= '0;
      overflow  <= FLAG_NONE;
    end else if (advance) begin
      out_valid <= v3;
      z         <= z_d;
      overflow  <= flag_d;
    end
  end

endmodule

// File: doc/float_mul_pipe.md
# float_mul_pipe

Parametrised, fully pipelined floating-point multiplier; next generation of the floating-point unit's single-cycle multiplier. Accepts one operand pair per cycle through a valid/ready handshake, produces a round-to-nearest-even product four cycles later, and reports exception status on a 2-bit flag bus. It sits in the floating-point unit beside the adder, and downstream stalls propagate back to the operand source.

## Interface
- EXP_W, 8: exponent width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23: stored fraction width; word width W = 1+EXP_W+MAN_W.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  operand pair x/y present.
- in_ready  out  1  pipeline accepts this cycle.
- x  in  W  operand A, IEEE-754 layout {sign, exp, frac}.
- y  in  W  operand B.
- out_valid  out  1  z/overflow hold a result.
- out_ready  in  1  consumer takes the result.
- z  out  W  product.
- overflow  out  2  status: 00 normal, 01 overflow (±inf), 10 underflow (flushed to ±0), 11 invalid (NaN).

## Operation
- Transfer on input when in_valid & in_ready; on output when out_valid & out_ready.
- Global advance = ~out_valid | out_ready; in_ready = advance (combinational from out_ready). All stage registers load only on advance; each stage carries a valid bit.
- S1 unpack: classify zero/subnormal (exp==0, flushed to zero on input), inf, NaN; sign = xs^ys; exponent sum ex+ey-bias in EXP_W+2 signed bits; hidden bits attached.
- S2 multiply: (MAN_W+1)x(MAN_W+1) unsigned product, 2*MAN_W+2 bits.
- S3 normalise/round: if product MSB set, shift right 1 and exponent+1; guard/round/sticky; round to nearest, ties to even; mantissa carry-out re-normalises (exponent+1).
- S4 pack/flags, priority: NaN input or inf*0 -> canonical quiet NaN {0, all-ones exp, 1 then zeros}, flag 11; inf operand -> signed inf, flag 00; zero operand -> signed zero, flag 00; biased exp >= 2^EXP_W-1 -> signed inf, flag 01; biased exp <= 0 -> signed zero, flag 10 (no subnormal output); else normal, flag 00.
- Flags accompany their own result only; no sticky accumulation.

## Timing
- Reset: all stage valids 0, out_valid 0, z 0, overflow 00; in_ready 1 after reset.
- Latency: accept at edge N -> out_valid high after edge N+4, given no stalls.
- Throughput: one result per cycle while out_ready is high.
- Stall: out_valid & ~out_ready freezes all stages; z/overflow held stable; in_ready 0.
- Bubbles: in_valid low during advance inserts an invalid slot; output drains without new input.
- Simultaneous output take and input accept in one cycle is legal, with no lost or duplicated results.
- rst asserted mid-stream discards all in-flight results; out_valid falls asynchronously.

## Structure
- Package float_pkg: flag encodings (FLAG_NONE/OVF/UDF/NAN), class enum (ZERO, NORM, INF, NAN), bias and canonical-NaN functions of EXP_W/MAN_W.
- One sub-module: float_round_ne (combinational normalise plus round-nearest-even, with exponent adjust), instantiated in S3.

## Test plan
- Basic: x=y=0x40C00000 (6.0) -> z=0x42100000 (36.0), flag 00, out_valid exactly 4 cycles after accept.
- Rounding: x=y=0x3F800800 (tie case) -> z=0x3F801000, flag 00; x=y=0x3F800001 -> z=0x3F800002.
- Exceptions:
  - 0x7F000000 * 0x40000000 -> 0x7F800000, flag 01.
  - 0x00800000 * 0x3F000000 -> 0x00000000, flag 10.
  - 0x7F800000 * 0x00000000 -> 0x7FC00000, flag 11.
  - 0xFF800000 * 0x40000000 -> 0xFF800000, flag 00.
- Back-pressure: stream 8 distinct pairs with out_ready toggled pseudo-randomly -> all 8 products emerge in order, none dropped or duplicated, z stable while stalled.
- Reset mid-stream: assert rst with 3 results in flight -> out_valid 0 immediately; after release, no stale results appear and the next pair has 4-cycle latency.
- Parameter sweep: EXP_W=5, MAN_W=10 (half precision), 0x3E00*0x3E00 (1.5*1.5) -> 0x4080, flag 00.
